// File: rtl/segment_led_pkg.sv
// Shared constants for the segment LED bus format: glyph table, flag bit positions, decoder states.
package segment_led_pkg;

  localparam int DIGITS = 10;

  localparam logic [6:0] GLYPH [DIGITS] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f
  };

  localparam int DP_HUND_1 = 7;
  localparam int DP_HUND_2 = 7;
  localparam int RST_BIT   = 8;

  typedef enum logic [1:0] {
    S_SRC_RST = 2'd0,
    S_SETTLE  = 2'd1,
    S_STABLE  = 2'd2
  } state_t;

endpackage

// File: rtl/segment_glyph_decode.sv
// Maps a 7-segment glyph back to its decimal digit; valid=0 for any glyph outside the table.
module segment_glyph_decode
  import segment_led_pkg::*;
(
  input  logic [6:0] glyph,
  output logic       valid,
  output logic [3:0] digit
);

  always_comb begin
    valid = 1'b0;
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (glyph == GLYPH[i]) begin
        valid = 1'b1;
        digit = 4'(i);
      end
    end
  end

endmodule

// File: rtl/segment_led_decoder.sv
// Recovers the 8-bit count from two synchronised, debounced segment LED buses and
// presents it on a valid/ready port with decode-error, overrun and source-reset flags.
module segment_led_decoder
  import segment_led_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [8:0] segment_led_1_i,
  input  logic [8:0] segment_led_2_i,
  output logic [7:0] count_o,
  output logic       count_valid_o,
  input  logic       count_ready_i,
  output logic       decode_err_o,
  output logic       overrun_o,
  output logic       src_rst_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  function automatic logic [8:0] times10(input logic [3:0] d);
    return ({5'd0, d} << 3) + ({5'd0, d} << 1);
  endfunction

  logic [SYNC_STAGES-1:0][17:0] sync_q;
  logic [17:0]      p_cur, p_prev, last_pat;
  logic [8:0]       led1, led2;
  logic             last_vld, same, src_rst_req, strobe;
  logic [CNT_W-1:0] stab_cnt, run_cnt;
  state_t           state;

  // Input synchroniser
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], segment_led_1_i, segment_led_2_i};
  end

  assign p_cur       = sync_q[SYNC_STAGES-1];
  assign led1        = p_cur[17:9];
  assign led2        = p_cur[8:0];
  assign same        = (p_cur == p_prev);
  assign src_rst_req = led1[RST_BIT] | led2[RST_BIT];
  // run_cnt counts how many earlier samples matched the current one
  assign run_cnt     = same ? stab_cnt + 1'b1 : '0;
  assign strobe      = (state == S_SETTLE) && !src_rst_req && (run_cnt == CNT_LAST) &&
                       !(last_vld && (p_cur == last_pat));

  // Stability tracking and FSM
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_SRC_RST;
      stab_cnt <= '0;
      p_prev   <= '0;
      last_pat <= '0;
      last_vld <= 1'b0;
    end else begin
      p_prev <= p_cur;
      if (src_rst_req) begin
        state    <= S_SRC_RST;
        stab_cnt <= '0;
        last_vld <= 1'b0;
      end else begin
        case (state)
          S_SRC_RST: begin
            state    <= S_SETTLE;
            stab_cnt <= '0;
          end
          S_SETTLE: begin
            if (run_cnt == CNT_LAST) begin
              state    <= S_STABLE;
              stab_cnt <= '0;
              last_vld <= 1'b1;
              last_pat <= p_cur;
            end else begin
              stab_cnt <= run_cnt;
            end
          end
          S_STABLE: begin
            if (!same) begin
              state    <= S_SETTLE;
              stab_cnt <= '0;
            end
          end
          default: state <= S_SRC_RST;
        endcase
      end
    end
  end

  logic       tens_ok, ones_ok, hund_ok, dec_ok;
  logic [3:0] tens, ones;
  logic [8:0] hund_val, value;

  segment_glyph_decode u_tens (.glyph(led1[6:0]), .valid(tens_ok), .digit(tens));
  segment_glyph_decode u_ones (.glyph(led2[6:0]), .valid(ones_ok), .digit(ones));

  // Hundreds flags are thermometer coded; {1,0} cannot come from a legal source
  always_comb begin
    hund_ok  = 1'b1;
    hund_val = 9'd0;
    case ({led1[DP_HUND_1], led2[DP_HUND_2]})
      2'b00:   hund_val = 9'd0;
      2'b01:   hund_val = 9'd100;
      2'b11:   hund_val = 9'd200;
      default: hund_ok  = 1'b0;
    endcase
  end

  assign value  = hund_val + times10(tens) + {5'd0, ones};
  assign dec_ok = tens_ok & ones_ok & hund_ok & ~value[8];

  // Output register and handshake
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_o       <= '0;
      count_valid_o <= 1'b0;
      decode_err_o  <= 1'b0;
      overrun_o     <= 1'b0;
      src_rst_o     <= 1'b0;
    end else begin
      decode_err_o <= strobe & ~dec_ok;
      overrun_o    <= strobe & dec_ok & count_valid_o & ~count_ready_i;
      src_rst_o    <= src_rst_req;
      if (strobe && dec_ok) begin
        count_o       <= value[7:0];
        count_valid_o <= 1'b1;
      end else if (count_valid_o && count_ready_i) begin
        count_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segment_led_decoder.sv
// Scoreboard bench for segment_led_decoder: expected results queued at drive time, checked by a monitor.
module tb_segment_led_decoder;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [8:0] segment_led_1_i, segment_led_2_i;
  logic [7:0] count_o;
  logic       count_valid_o, count_ready_i, decode_err_o, overrun_o, src_rst_o;

  segment_led_decoder #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .segment_led_1_i(segment_led_1_i), .segment_led_2_i(segment_led_2_i),
    .count_o(count_o), .count_valid_o(count_valid_o), .count_ready_i(count_ready_i),
    .decode_err_o(decode_err_o), .overrun_o(overrun_o), .src_rst_o(src_rst_o)
  );

  always #5 clk_i = ~clk_i;

  logic [6:0] gl [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  int tests = 0, fails = 0;
  int exp_err = 0, exp_ovr = 0, err_seen = 0, ovr_seen = 0;
  int q[$];
  bit last_ok = 0;
  logic [17:0] last_pat = '0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int digit_of(input logic [6:0] g);
    for (int i = 0; i < 10; i++) if (gl[i] == g) return i;
    return -1;
  endfunction

  function automatic void model(input logic [8:0] l1, input logic [8:0] l2, output bit err, output int val);
    int t, o, h;
    t = digit_of(l1[6:0]);
    o = digit_of(l2[6:0]);
    if (l1[7] && !l2[7]) h = -1;
    else h = int'(l1[7]) + int'(l2[7]);
    val = 100 * h + 10 * t + o;
    err = (t < 0) || (o < 0) || (h < 0) || (val > 255);
  endfunction

  task automatic apply(input logic [8:0] l1, input logic [8:0] l2);
    bit err;
    int val;
    segment_led_1_i = l1;
    segment_led_2_i = l2;
    if (!(last_ok && {l1, l2} == last_pat)) begin
      model(l1, l2, err, val);
      last_ok  = 1;
      last_pat = {l1, l2};
      if (err) exp_err++;
      else begin
        if (!count_ready_i && q.size() > 0) begin
          exp_ovr++;
          void'(q.pop_back());
        end
        q.push_back(val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic check_sb(input string name, input int exp_q);
    chk({name, " errors"}, err_seen, exp_err);
    chk({name, " overruns"}, ovr_seen, exp_ovr);
    chk({name, " pending"}, q.size(), exp_q);
  endtask

  task automatic set_ready(input logic r);
    count_ready_i = r;
    cyc(2);
  endtask

  // Monitor: counts pulses and checks every accepted transfer against the queue
  initial begin
    int e;
    forever begin
      @(negedge clk_i);
      if (decode_err_o) err_seen++;
      if (overrun_o) ovr_seen++;
      if (count_valid_o && count_ready_i) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL xfer: got unexpected count %0d, expected no transfer", count_o);
        end else begin
          e = q.pop_front();
          chk("xfer count", int'(count_o), e);
        end
      end
    end
  end

  initial begin
    int n;
    logic [8:0] l1, l2;
    rst_n_i = 1'b0;
    count_ready_i = 1'b1;
    segment_led_1_i = '0;
    segment_led_2_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst count", int'(count_o), 0);
    chk("rst valid", int'(count_valid_o), 0);
    chk("rst err", int'(decode_err_o), 0);
    chk("rst ovr", int'(overrun_o), 0);
    chk("rst src", int'(src_rst_o), 0);
    @(posedge clk_i); #2;
    rst_n_i = 1'b1;
    apply(9'h000, 9'h000);
    cyc(10);
    check_sb("startup", 0);

    // 123 with latency measurement
    apply(9'h05b, 9'h0cf);
    n = 0;
    while (n < 20 && !count_valid_o) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("latency edges", n, 6);
    @(posedge clk_i); #1;
    chk("123 valid one cycle", int'(count_valid_o), 0);
    cyc(8);
    check_sb("123", 0);

    // 255 held under back-pressure
    set_ready(1'b0);
    apply(9'h0ed, 9'h0ed);
    cyc(16);
    chk("255 held valid", int'(count_valid_o), 1);
    chk("255 held count", int'(count_o), 255);
    count_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("255 valid after accept", int'(count_valid_o), 0);
    cyc(4);
    check_sb("255", 0);

    // Decode errors
    apply(9'h05b, 9'h077); cyc(10);
    apply(9'h0ed, 9'h0fd); cyc(10);
    apply(9'h0ed, 9'h06d); cyc(10);
    check_sb("errors", 0);
    chk("errors valid", int'(count_valid_o), 0);

    // Glitching input never settles
    segment_led_1_i = 9'h03f;
    for (int i = 0; i < 10; i++) begin
      segment_led_2_i = (i % 2 == 0) ? 9'h006 : 9'h05b;
      cyc(2);
    end
    apply(9'h03f, 9'h03f);
    cyc(10);
    check_sb("glitch", 0);

    // Overrun
    set_ready(1'b0);
    apply(9'h066, 9'h05b); cyc(12);
    apply(9'h006, 9'h007); cyc(12);
    chk("overrun count", int'(count_o), 17);
    chk("overrun valid", int'(count_valid_o), 1);
    cyc(10);
    check_sb("overrun", 1);
    set_ready(1'b1);
    cyc(4);
    check_sb("overrun drain", 0);

    // Source reset mid-settle, release to the last decoded pattern
    apply(9'h04f, 9'h066); cyc(10);
    segment_led_1_i = 9'h07f; segment_led_2_i = 9'h06f; cyc(2);
    segment_led_1_i = 9'h17f; cyc(5);
    chk("src_rst asserted", int'(src_rst_o), 1);
    last_ok = 0;
    apply(9'h04f, 9'h066); cyc(10);
    chk("src_rst released", int'(src_rst_o), 0);
    check_sb("src reset", 0);

    // Randomized patterns with random back-pressure
    for (int it = 0; it < 30; it++) begin
      set_ready($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0) begin
        n  = $urandom_range(0, 3);
        l1 = {1'b0, n[1], gl[$urandom_range(0, 9)]};
        l2 = {1'b0, n[0], gl[$urandom_range(0, 9)]};
      end else begin
        l1 = {1'b0, 8'($urandom)};
        l2 = {1'b0, 8'($urandom)};
      end
      apply(l1, l2);
      cyc(10);
    end
    set_ready(1'b1);
    cyc(4);
    check_sb("random", 0);

    // Async reset discards a pending result
    set_ready(1'b0);
    apply(9'h007, 9'h07f); cyc(10);
    chk("pre-reset valid", int'(count_valid_o), 1);
    rst_n_i = 1'b0;
    segment_led_1_i = '0;
    segment_led_2_i = '0;
    #1;
    chk("async reset valid", int'(count_valid_o), 0);
    q.delete();
    last_ok = 0;
    cyc(3);
    count_ready_i = 1'b1;
    rst_n_i = 1'b1;
    apply(9'h000, 9'h000);
    cyc(10);
    apply(9'h0cf, 9'h0ef);
    cyc(10);
    check_sb("after async reset", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
